// File: rtl/rib_arbiter.sv
// Three-master RIB bus arbiter (m0 JTAG > m1 EX > m2 fetch) with slave decode,
// bounded m0 bus ownership and a sticky decode-error capture.
module rib_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_SLV  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m0_req,
    input  logic                      m0_we,
    input  logic [ADDR_W-1:0]         m0_addr,
    input  logic [DATA_W-1:0]         m0_wdata,
    output logic                      m0_gnt,
    output logic [DATA_W-1:0]         m0_rdata,
    input  logic                      m1_req,
    input  logic                      m1_we,
    input  logic [ADDR_W-1:0]         m1_addr,
    input  logic [DATA_W-1:0]         m1_wdata,
    output logic                      m1_gnt,
    output logic [DATA_W-1:0]         m1_rdata,
    input  logic                      m2_req,
    input  logic                      m2_we,
    input  logic [ADDR_W-1:0]         m2_addr,
    input  logic [DATA_W-1:0]         m2_wdata,
    output logic                      m2_gnt,
    output logic [DATA_W-1:0]         m2_rdata,
    output logic [NUM_SLV-1:0]        s_req,
    output logic                      s_we,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    output logic                      hold_flag_o,
    output logic                      err_o,
    output logic [ADDR_W-1:0]         err_addr_o
);

    typedef enum logic {IDLE, LOCK0} state_t;

    localparam logic [4:0] NSLV = 5'(NUM_SLV);
    localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              cool_q, cool_d;
    logic              g0, g1, g2, any_gnt;
    logic              sel_we, dec_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, rd;
    logic [3:0]        idx;

    // Grant and decode are purely combinational so fetch/load reads see zero wait.
    always_comb begin
        g0        = ~rst & m0_req & ~cool_q;
        g1        = ~rst & ~g0 & m1_req;
        g2        = ~rst & ~g0 & ~m1_req & m2_req;
        any_gnt   = g0 | g1 | g2;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (g0) begin
            sel_we    = m0_we;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
        end else if (g1) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end else if (g2) begin
            sel_we    = m2_we;
            sel_addr  = m2_addr;
            sel_wdata = m2_wdata;
        end
        idx    = sel_addr[ADDR_W-1 -: 4];
        dec_ok = any_gnt && ({1'b0, idx} < NSLV);
        s_req  = '0;
        rd     = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dec_ok && idx == 4'(i)) begin
                s_req[i] = 1'b1;
                rd       = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign m0_gnt      = g0;
    assign m1_gnt      = g1;
    assign m2_gnt      = g2;
    assign m0_rdata    = g0 ? rd : '0;
    assign m1_rdata    = g1 ? rd : '0;
    assign m2_rdata    = g2 ? rd : '0;
    assign s_we        = sel_we;
    assign s_addr      = {4'b0000, sel_addr[ADDR_W-5:0]};
    assign s_wdata     = sel_wdata;
    assign hold_flag_o = ~rst & m2_req & ~g2;

    // The MAX_HOLD-th consecutive m0 grant releases the lock; the next cycle is the cool-down.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cool_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (g0) begin
                    state_d = LOCK0;
                    cnt_d   = 8'd1;
                end
            end
            LOCK0: begin
                if (!m0_req) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    cool_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            cool_q     <= 1'b0;
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cool_q  <= cool_d;
            if (any_gnt && !dec_ok) begin
                err_o <= 1'b1;
                if (!err_o) err_addr_o <= sel_addr;
            end
        end
    end

endmodule
